// File: rtl/traffic_light_ctrl.sv
// Vehicle light sequencer RED -> GREEN -> YELLOW on a tick timebase,
// with pedestrian-extended green and a WALK hold on green exit.
module traffic_light_ctrl #(
    parameter logic [7:0] RED_TIME       = 8'd20,
    parameter logic [7:0] GREEN_TIME     = 8'd30,
    parameter logic [7:0] GREEN_PED_TIME = 8'd60,
    parameter logic [7:0] YELLOW_TIME    = 8'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_request,
    input  logic       walk_light,
    output logic       red_trffc_light,
    output logic       ylw_trffc_light,
    output logic       grn_trffc_light,
    output logic       ped_pending,
    output logic [7:0] phase_timer
);

    typedef enum logic [1:0] {
        S_RED    = 2'b00,
        S_GREEN  = 2'b01,
        S_YELLOW = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       pend_q, pend_d;
    logic       red_q, ylw_q, grn_q;
    logic [7:0] limit;
    logic       at_limit;

    always_comb begin
        limit = RED_TIME;
        case (state_q)
            S_GREEN:  limit = pend_q ? GREEN_PED_TIME : GREEN_TIME;
            S_YELLOW: limit = YELLOW_TIME;
            default:  limit = RED_TIME;
        endcase
        // >= also covers a late request that leaves timer past the new limit
        at_limit = (timer_q >= (limit - 8'd1));
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pend_d  = pend_q | ped_request;
        case (state_q)
            S_RED: begin
                if (tick) begin
                    if (!at_limit) begin
                        timer_d = timer_q + 8'd1;
                    end else begin
                        state_d = S_GREEN;
                        timer_d = 8'd0;
                    end
                end
            end
            S_GREEN: begin
                if (tick) begin
                    if (!at_limit) begin
                        timer_d = timer_q + 8'd1;
                    end else if (!walk_light) begin
                        state_d = S_YELLOW;
                        timer_d = 8'd0;
                        pend_d  = ped_request;
                    end
                end
            end
            S_YELLOW: begin
                if (tick) begin
                    if (!at_limit) begin
                        timer_d = timer_q + 8'd1;
                    end else begin
                        state_d = S_RED;
                        timer_d = 8'd0;
                    end
                end
            end
            default: begin
                state_d = S_RED;
                timer_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RED;
            timer_q <= 8'd0;
            pend_q  <= 1'b0;
            red_q   <= 1'b1;
            ylw_q   <= 1'b0;
            grn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            red_q   <= (state_d == S_RED);
            ylw_q   <= (state_d == S_YELLOW);
            grn_q   <= (state_d == S_GREEN);
        end
    end

    assign red_trffc_light = red_q;
    assign ylw_trffc_light = ylw_q;
    assign grn_trffc_light = grn_q;
    assign ped_pending     = pend_q;
    assign phase_timer     = timer_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed literal checks plus
// randomized traffic compared every cycle against a phase model.
module tb_traffic_light_ctrl;

    localparam int RED = 2;
    localparam int GRN = 3;
    localparam int PED = 10;
    localparam int YEL = 2;

    logic       clk = 1'b0;
    logic       rst, tick, ped_request, walk_light;
    logic       red_o, ylw_o, grn_o, pend_o;
    logic [7:0] tmr_o;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    traffic_light_ctrl #(
        .RED_TIME(8'(RED)),
        .GREEN_TIME(8'(GRN)),
        .GREEN_PED_TIME(8'(PED)),
        .YELLOW_TIME(8'(YEL))
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .ped_request(ped_request),
        .walk_light(walk_light),
        .red_trffc_light(red_o),
        .ylw_trffc_light(ylw_o),
        .grn_trffc_light(grn_o),
        .ped_pending(pend_o),
        .phase_timer(tmr_o)
    );

    always #5 clk = ~clk;

    // model: phase 0=red, 1=green, 2=yellow
    int m_ph = 0;
    int m_tmr = 0;
    bit m_pend = 1'b0;

    function automatic int lim(int ph, bit pend);
        if (ph == 0) return RED;
        if (ph == 2) return YEL;
        return pend ? PED : GRN;
    endfunction

    always @(posedge clk) begin
        int  L;
        bit  ex;
        if (rst) begin
            m_ph   <= 0;
            m_tmr  <= 0;
            m_pend <= 1'b0;
        end else begin
            L  = lim(m_ph, m_pend);
            ex = tick && (m_tmr >= L - 1) && !(m_ph == 1 && walk_light);
            if (ex) begin
                m_ph  <= (m_ph + 1) % 3;
                m_tmr <= 0;
            end else if (tick && m_tmr < L - 1) begin
                m_tmr <= m_tmr + 1;
            end
            if (ped_request) m_pend <= 1'b1;
            else if (ex && m_ph == 1) m_pend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [2:0] exp_ryg;
        if (chk_on) begin
            exp_ryg = {m_ph == 0, m_ph == 2, m_ph == 1};
            vectors++;
            if ({red_o, ylw_o, grn_o} !== exp_ryg ||
                tmr_o !== 8'(m_tmr) || pend_o !== m_pend) begin
                miscompares++;
                $display("FAIL model @%0t: got ryg=%b t=%0d p=%b, want ryg=%b t=%0d p=%b",
                         $time, {red_o, ylw_o, grn_o}, tmr_o, pend_o,
                         exp_ryg, m_tmr, m_pend);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [2:0] ryg, int t, logic p);
        vectors++;
        if ({red_o, ylw_o, grn_o} !== ryg || tmr_o !== 8'(t) || pend_o !== p) begin
            miscompares++;
            $display("FAIL %s: got ryg=%b t=%0d p=%b, want ryg=%b t=%0d p=%b",
                     nm, {red_o, ylw_o, grn_o}, tmr_o, pend_o, ryg, t, p);
        end
    endtask

    initial begin
        int yl_cnt;
        bit yl_seen, yl_done;
        rst = 1'b1; tick = 1'b1; ped_request = 1'b0; walk_light = 1'b0;
        step();
        chk_on = 1'b1;
        chk("reset", 3'b100, 0, 0);

        rst = 1'b0;
        step(); chk("red_t1", 3'b100, 1, 0);
        step(); chk("grn_t0", 3'b001, 0, 0);
        step(); step(); chk("grn_t2", 3'b001, 2, 0);
        step(); chk("ylw_t0", 3'b010, 0, 0);
        step(); step(); chk("red_again", 3'b100, 0, 0);

        // request during red
        ped_request = 1'b1; step(); ped_request = 1'b0;
        chk("ped_latch", 3'b100, 1, 1);
        step(); chk("grn_ped_t0", 3'b001, 0, 1);
        repeat (9) step();
        chk("grn_ped_t9", 3'b001, 9, 1);
        step(); chk("ped_clear", 3'b010, 0, 0);
        step(); step(); chk("red_t0_b", 3'b100, 0, 0);

        // request mid-green extends current green
        step(); step(); step();
        ped_request = 1'b1; step(); ped_request = 1'b0;
        chk("mid_ext", 3'b001, 2, 1);
        repeat (7) step();
        chk("mid_ext_t9", 3'b001, 9, 1);
        step(); chk("mid_ext_exit", 3'b010, 0, 0);
        step(); step();

        // request on the green exit cycle survives
        step(); step(); step(); step();
        ped_request = 1'b1; step(); ped_request = 1'b0;
        chk("exit_req_ylw", 3'b010, 0, 1);
        step(); step(); chk("exit_req_red", 3'b100, 0, 1);
        step(); step(); chk("exit_req_grn", 3'b001, 0, 1);
        repeat (9) step();
        chk("exit_req_t9", 3'b001, 9, 1);
        step(); chk("exit_req_clr", 3'b010, 0, 0);
        step(); step();

        // walk hold; walk also high during red, where it is ignored
        walk_light = 1'b1;
        step(); step(); chk("walk_red_ign", 3'b001, 0, 0);
        step(); step();
        repeat (7) step();
        chk("walk_hold", 3'b001, 2, 0);
        walk_light = 1'b0;
        step(); chk("walk_release", 3'b010, 0, 0);
        step(); step();

        // reset on an exit cycle
        step(); step(); step(); step();
        rst = 1'b1; ped_request = 1'b1;
        step();
        rst = 1'b0; ped_request = 1'b0;
        chk("rst_exit", 3'b100, 0, 0);

        // sparse tick: yellow must span 2 ticks = 8 clocks
        yl_cnt = 0; yl_seen = 1'b0; yl_done = 1'b0;
        for (int c = 0; c < 64; c++) begin
            tick = (c % 4 == 0);
            step();
            if (ylw_o && !yl_done) begin
                yl_cnt++;
                yl_seen = 1'b1;
            end else if (yl_seen) begin
                yl_done = 1'b1;
            end
        end
        vectors++;
        if (yl_cnt != 8) begin
            miscompares++;
            $display("FAIL sparse_yellow: got %0d clocks, want 8", yl_cnt);
        end

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            tick = ($urandom_range(0, 2) != 0);
            ped_request = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) walk_light = ~walk_light;
            step();
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
